// File: rtl/coh_pkg.sv
// Shared types and defaults for the write-back coherency snoop path.
package coh_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam data_t INVALID_DATA = '0;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ACK    = 2'd2
    } snoop_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry write-back FIFO; head slot holds its last value once drained.
module wb_fifo
    import coh_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  wb_entry_t  din,
    input  logic       pop,
    output wb_entry_t  dout,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    wb_entry_t slot0, slot1;

    assign dout  = slot0;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // Shift-style storage: slot0 is always the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'(1);
                end
                2'b01: begin
                    if (count == 2'd2) slot0 <= slot1;
                    count <= count - 2'(1);
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/snoop_inv_responder.sv
// Remote-cache snoop responder: invalidates on bus_req, acks two cycles later,
// and queues dirty victims for write-back. Also owns line state with fill/read ports.
module snoop_inv_responder #(
    parameter int unsigned ADDR_W = coh_pkg::ADDR_W,
    parameter int unsigned DATA_W = coh_pkg::DATA_W,
    parameter int unsigned CNT_W  = coh_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bus_req,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rdy,
    output logic              bus_ack,
    input  logic              fill_valid,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_dirty,
    output logic              fill_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    output logic [CNT_W-1:0]  inv_cnt
);
    import coh_pkg::*;

    localparam int unsigned LINES = 2**ADDR_W;

    snoop_state_e      state, state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [DATA_W-1:0] data_q [LINES];

    logic              accept_c, lookup_c, fill_acc_c, line_hit_c, push_c, pop_c;
    logic              rd_hit_nxt_c;
    logic [DATA_W-1:0] rd_data_nxt_c;
    wb_entry_t         push_entry, head;
    logic [1:0]        fifo_count;
    logic              fifo_full, fifo_empty;

    assign bus_rdy    = (state == IDLE) && !fifo_full;
    assign fill_ready = (state == IDLE) && !(bus_req && bus_rdy);
    assign accept_c   = bus_req && bus_rdy;
    assign fill_acc_c = fill_valid && fill_ready;
    assign lookup_c   = (state == LOOKUP);
    assign line_hit_c = valid_q[lat_addr];
    assign push_c     = lookup_c && line_hit_c && dirty_q[lat_addr];
    assign pop_c      = mem_wr_valid && mem_wr_ready;

    assign push_entry.addr = lat_addr;
    assign push_entry.data = data_q[lat_addr];

    wb_fifo u_wb_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .din     (push_entry),
        .pop     (pop_c),
        .dout    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mem_wr_valid = !fifo_empty;
    assign mem_wr_addr  = head.addr;
    assign mem_wr_data  = head.data;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_c) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_addr <= '0;
            bus_ack  <= 1'b0;
            inv_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            bus_ack <= lookup_c;
            if (accept_c) lat_addr <= bus_addr;
            if (lookup_c && line_hit_c && (inv_cnt != '1))
                inv_cnt <= inv_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (lookup_c) begin
            valid_q[lat_addr] <= 1'b0;
            dirty_q[lat_addr] <= 1'b0;
        end else if (fill_acc_c) begin
            valid_q[fill_addr] <= 1'b1;
            dirty_q[fill_addr] <= fill_dirty;
        end
    end

    // Data array has no reset; reads are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (lookup_c)        data_q[lat_addr]  <= INVALID_DATA;
        else if (fill_acc_c) data_q[fill_addr] <= fill_data;
    end

    // Read returns the line as it stands after this edge's update.
    always_comb begin
        rd_hit_nxt_c  = valid_q[rd_addr];
        rd_data_nxt_c = data_q[rd_addr];
        if (lookup_c && (rd_addr == lat_addr)) begin
            rd_hit_nxt_c  = 1'b0;
            rd_data_nxt_c = INVALID_DATA;
        end else if (fill_acc_c && (rd_addr == fill_addr)) begin
            rd_hit_nxt_c  = 1'b1;
            rd_data_nxt_c = fill_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else if (rd_en) begin
            rd_hit  <= rd_hit_nxt_c;
            rd_data <= rd_hit_nxt_c ? rd_data_nxt_c : INVALID_DATA;
        end
    end

endmodule

// File: tb/tb_snoop_inv_responder.sv
// Directed self-checking bench for snoop_inv_responder.
module tb_snoop_inv_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bus_req;
    logic [9:0]  bus_addr;
    logic        bus_rdy;
    logic        bus_ack;
    logic        fill_valid;
    logic [9:0]  fill_addr;
    logic [15:0] fill_data;
    logic        fill_dirty;
    logic        fill_ready;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        rd_hit;
    logic [15:0] rd_data;
    logic        mem_wr_valid;
    logic [9:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ready;
    logic [15:0] inv_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snoop_inv_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_rdy      (bus_rdy),
        .bus_ack      (bus_ack),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_dirty   (fill_dirty),
        .fill_ready   (fill_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_hit       (rd_hit),
        .rd_data      (rd_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .inv_cnt      (inv_cnt)
    );

    task automatic do_fill(input logic [9:0] a, input logic [15:0] d, input logic dty);
        @(negedge clk);
        fill_valid = 1'b1; fill_addr = a; fill_data = d; fill_dirty = dty;
        @(negedge clk);
        fill_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, output logic h, output logic [15:0] d);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        h = rd_hit; d = rd_data;
    endtask

    // Returns at the negedge just after the accepting edge (state LOOKUP).
    task automatic do_snoop(input logic [9:0] a);
        int n;
        @(negedge clk);
        bus_req = 1'b1; bus_addr = a;
        n = 0;
        while (!bus_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus_rdy) begin
            errors++;
            $display("FAIL snoop_accept_timeout: bus_rdy=%b required 1", bus_rdy);
        end
        @(negedge clk);
        bus_req = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_fr;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus_ack, rd_hit, mem_wr_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: ack/hit/mwv=%b required 000", {bus_ack, rd_hit, mem_wr_valid});
        end
        checks++;
        if (rd_data !== 16'h0 || mem_wr_addr !== 10'h0 || mem_wr_data !== 16'h0 || inv_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_values: rd_data=%h mwa=%h mwd=%h cnt=%h required 0", rd_data, mem_wr_addr, mem_wr_data, inv_cnt);
        end
        bus_req = 1'b1;
        exp_fr = 1'b0;
        #1;
        checks++;
        if (bus_rdy !== 1'b1 || fill_ready !== exp_fr) begin
            errors++; $display("FAIL reset_comb: bus_rdy=%b fill_ready=%b required 1 %b", bus_rdy, fill_ready, exp_fr);
        end
        bus_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_clean_snoop();
        logic h; logic [15:0] d;
        do_fill(10'h005, 16'h0042, 1'b0);
        do_read(10'h005, h, d);
        checks++;
        if (h !== 1'b1 || d !== 16'h0042) begin
            errors++; $display("FAIL clean_fill_read: hit=%b data=%h required 1 0042", h, d);
        end
        do_snoop(10'h005);
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL clean_ack_e1: got %b required 0", bus_ack); end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1 || mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL clean_ack_e2: ack=%b mwv=%b required 1 0", bus_ack, mem_wr_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || inv_cnt !== 16'd1 || mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL clean_after: ack=%b cnt=%0d mwv=%b required 0 1 0", bus_ack, inv_cnt, mem_wr_valid);
        end
        do_read(10'h005, h, d);
        checks++;
        if (h !== 1'b0 || d !== 16'h0) begin
            errors++; $display("FAIL clean_invalidated: hit=%b data=%h required 0 0000", h, d);
        end
    endtask

    task automatic test_dirty_snoop();
        logic h; logic [15:0] d;
        mem_wr_ready = 1'b1;
        do_fill(10'h010, 16'h0063, 1'b1);
        do_snoop(10'h010);
        checks++;
        if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL dirty_mwv_e1: got %b required 0", mem_wr_valid); end
        @(negedge clk);
        checks++;
        if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 10'h010 || mem_wr_data !== 16'h0063 || bus_ack !== 1'b1) begin
            errors++; $display("FAIL dirty_wb_e2: mwv=%b addr=%h data=%h ack=%b required 1 010 0063 1", mem_wr_valid, mem_wr_addr, mem_wr_data, bus_ack);
        end
        @(negedge clk);
        checks++;
        if (mem_wr_valid !== 1'b0 || mem_wr_addr !== 10'h010) begin
            errors++; $display("FAIL dirty_single_pop: mwv=%b addr=%h required 0 010", mem_wr_valid, mem_wr_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_wr_valid !== 1'b0 || inv_cnt !== 16'd2) begin
            errors++; $display("FAIL dirty_after: mwv=%b cnt=%0d required 0 2", mem_wr_valid, inv_cnt);
        end
        do_read(10'h010, h, d);
        checks++;
        if (h !== 1'b0 || d !== 16'h0) begin
            errors++; $display("FAIL dirty_invalidated: hit=%b data=%h required 0 0000", h, d);
        end
    endtask

    task automatic test_read_timing();
        do_fill(10'h030, 16'h0555, 1'b0);
        @(negedge clk);
        bus_req = 1'b1; bus_addr = 10'h030;
        rd_en = 1'b1; rd_addr = 10'h030;
        @(negedge clk);
        bus_req = 1'b0;
        checks++;
        if (rd_hit !== 1'b1 || rd_data !== 16'h0555) begin
            errors++; $display("FAIL rd_at_e0_old: hit=%b data=%h required 1 0555", rd_hit, rd_data);
        end
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_hit !== 1'b0 || rd_data !== 16'h0) begin
            errors++; $display("FAIL rd_at_e1_new: hit=%b data=%h required 0 0000", rd_hit, rd_data);
        end
        @(negedge clk);
        checks++;
        if (inv_cnt !== 16'd3) begin errors++; $display("FAIL rd_timing_cnt: got %0d required 3", inv_cnt); end
    endtask

    task automatic test_back_to_back();
        mem_wr_ready = 1'b0;
        do_fill(10'h001, 16'h0111, 1'b1);
        do_fill(10'h002, 16'h0222, 1'b1);
        do_snoop(10'h001);
        repeat (2) @(negedge clk);
        do_snoop(10'h002);
        repeat (2) @(negedge clk);
        checks++;
        if (bus_rdy !== 1'b0 || mem_wr_valid !== 1'b1 || mem_wr_addr !== 10'h001 || mem_wr_data !== 16'h0111) begin
            errors++; $display("FAIL bp_full: rdy=%b mwv=%b addr=%h data=%h required 0 1 001 0111", bus_rdy, mem_wr_valid, mem_wr_addr, mem_wr_data);
        end
        do_fill(10'h003, 16'h0333, 1'b1);
        @(negedge clk);
        bus_req = 1'b1; bus_addr = 10'h003;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_rdy !== 1'b0 || bus_ack !== 1'b0 || inv_cnt !== 16'd5) begin
            errors++; $display("FAIL bp_held: rdy=%b ack=%b cnt=%0d required 0 0 5", bus_rdy, bus_ack, inv_cnt);
        end
        mem_wr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 10'h002 || mem_wr_data !== 16'h0222 || bus_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_drain2: mwv=%b addr=%h data=%h rdy=%b required 1 002 0222 1", mem_wr_valid, mem_wr_addr, mem_wr_data, bus_rdy);
        end
        @(negedge clk);
        bus_req = 1'b0;
        checks++;
        if (mem_wr_valid !== 1'b0 || bus_ack !== 1'b0 || bus_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_third_accept: mwv=%b ack=%b rdy=%b required 0 0 0", mem_wr_valid, bus_ack, bus_rdy);
        end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1 || mem_wr_valid !== 1'b1 || mem_wr_addr !== 10'h003 || mem_wr_data !== 16'h0333) begin
            errors++; $display("FAIL bp_third_wb: ack=%b mwv=%b addr=%h data=%h required 1 1 003 0333", bus_ack, mem_wr_valid, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        checks++;
        if (mem_wr_valid !== 1'b0 || inv_cnt !== 16'd6) begin
            errors++; $display("FAIL bp_done: mwv=%b cnt=%0d required 0 6", mem_wr_valid, inv_cnt);
        end
    endtask

    task automatic test_invalid_wrap();
        do_snoop(10'h3FF);
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1 || mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_ack: ack=%b mwv=%b required 1 0", bus_ack, mem_wr_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || inv_cnt !== 16'd6 || mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_after: ack=%b cnt=%0d mwv=%b required 0 6 0", bus_ack, inv_cnt, mem_wr_valid);
        end
    endtask

    task automatic test_fill_priority();
        logic h; logic [15:0] d;
        @(negedge clk);
        fill_valid = 1'b1; fill_addr = 10'h020; fill_data = 16'h0AAA; fill_dirty = 1'b0;
        bus_req = 1'b1; bus_addr = 10'h021;
        #1;
        checks++;
        if (fill_ready !== 1'b0 || bus_rdy !== 1'b1) begin
            errors++; $display("FAIL prio_same_cycle: fill_ready=%b rdy=%b required 0 1", fill_ready, bus_rdy);
        end
        @(negedge clk);
        bus_req = 1'b0;
        #1;
        checks++;
        if (fill_ready !== 1'b0) begin errors++; $display("FAIL prio_lookup: fill_ready=%b required 0", fill_ready); end
        @(negedge clk);
        checks++;
        if (fill_ready !== 1'b0 || bus_ack !== 1'b1) begin
            errors++; $display("FAIL prio_ack: fill_ready=%b ack=%b required 0 1", fill_ready, bus_ack);
        end
        @(negedge clk);
        checks++;
        if (fill_ready !== 1'b1) begin errors++; $display("FAIL prio_idle: fill_ready=%b required 1", fill_ready); end
        @(negedge clk);
        fill_valid = 1'b0;
        do_read(10'h020, h, d);
        checks++;
        if (h !== 1'b1 || d !== 16'h0AAA) begin
            errors++; $display("FAIL prio_filled: hit=%b data=%h required 1 0aaa", h, d);
        end
    endtask

    task automatic test_reset_mid();
        logic h; logic [15:0] d;
        mem_wr_ready = 1'b0;
        do_fill(10'h040, 16'h0777, 1'b1);
        do_snoop(10'h040);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_ack !== 1'b0 || mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_reset: ack=%b mwv=%b required 0 0", bus_ack, mem_wr_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || mem_wr_valid !== 1'b0 || inv_cnt !== 16'd0 || bus_rdy !== 1'b1) begin
            errors++; $display("FAIL rstmid_after: ack=%b mwv=%b cnt=%0d rdy=%b required 0 0 0 1", bus_ack, mem_wr_valid, inv_cnt, bus_rdy);
        end
        do_read(10'h040, h, d);
        checks++;
        if (h !== 1'b0 || d !== 16'h0) begin errors++; $display("FAIL rstmid_line40: hit=%b data=%h required 0 0000", h, d); end
        do_read(10'h020, h, d);
        checks++;
        if (h !== 1'b0 || d !== 16'h0) begin errors++; $display("FAIL rstmid_line20: hit=%b data=%h required 0 0000", h, d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus_req = 1'b0; bus_addr = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_data = '0; fill_dirty = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        mem_wr_ready = 1'b0;
        test_reset();
        test_clean_snoop();
        test_dirty_snoop();
        test_read_timing();
        test_back_to_back();
        test_invalid_wrap();
        test_fill_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
